// File: rtl/wb_periph_ic_pkg.sv
// Shared types and constants for the Wishbone peripheral interconnect:
// FSM encoding, slot decode geometry and the populated-slot map.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ic_state_t;

  localparam int DATA_W    = 32;
  localparam int SEL_W     = 4;
  localparam int SLOT_LSB  = 17;
  localparam int SLOT_W    = 3;
  localparam int NUM_SLOTS = 1 << SLOT_W;

  localparam int SLOT_TMR   = 0;
  localparam int SLOT_UART  = 1;
  localparam int SLOT_PSRAM = 2;
  localparam int SLOT_DAC   = 4;
  localparam int SLOT_ADC   = 5;

  localparam logic [NUM_SLOTS-1:0] DEFAULT_SLOT_MASK =
    NUM_SLOTS'((1 << SLOT_TMR) | (1 << SLOT_UART) | (1 << SLOT_PSRAM) |
               (1 << SLOT_DAC) | (1 << SLOT_ADC));

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    slot_onehot    = '0;
    slot_onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_periph_ic_if.sv
// Bus bundle of the interconnect: host-side Wishbone slave port plus the
// shared peripheral-side master port with per-slot strobes, acks and read data.
interface wb_periph_ic_if;
  import wb_ic_pkg::*;

  // Classic Wishbone: a request is cyc & stb held with stable adr/dat/sel/we
  // until the responder returns a single-cycle ack; dropping cyc abandons it.
  logic                        wbs_cyc_i;
  logic                        wbs_stb_i;
  logic                        wbs_we_i;
  logic [SEL_W-1:0]            wbs_sel_i;
  logic [DATA_W-1:0]           wbs_adr_i;
  logic [DATA_W-1:0]           wbs_dat_i;
  logic                        wbs_ack_o;
  logic [DATA_W-1:0]           wbs_dat_o;

  logic                        s_cyc_o;
  logic                        s_we_o;
  logic [NUM_SLOTS-1:0]        s_stb_o;
  logic [DATA_W-1:0]           s_adr_o;
  logic [DATA_W-1:0]           s_dat_o;
  logic [SEL_W-1:0]            s_sel_o;
  logic [NUM_SLOTS-1:0]        s_ack_i;
  logic [NUM_SLOTS*DATA_W-1:0] s_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output s_cyc_o, s_we_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s_cyc_o, s_we_o, s_stb_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i
  );

endinterface

// File: rtl/wb_periph_ic_timeout.sv
// Loadable up-counter that flags when TIMEOUT-1 cycles have elapsed since load.
module wb_ic_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/wb_periph_ic.sv
// Registered Wishbone interconnect: decodes adr[19:17] into eight slots,
// forwards one transfer at a time and self-terminates unmapped or stalled ones.
module wb_periph_ic
  import wb_ic_pkg::*;
#(
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK    = DEFAULT_SLOT_MASK,
  parameter int                   TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]    DEFAULT_DATA = 32'hDEADBEEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_periph_ic_if.slave     bus,
  input  logic              err_clr_i,
  output logic              err_o,
  output logic [SLOT_W-1:0] err_slot_o,
  output ic_state_t         dbg_state
);

  ic_state_t         state;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] req_slot;
  logic [DATA_W-1:0] slot_rdata;
  logic              req;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_tc;

  assign req      = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign req_slot = bus.wbs_adr_i[SLOT_LSB +: SLOT_W];
  // Read mux keyed by the latched slot so a changing host address cannot glitch it.
  assign slot_rdata = bus.s_dat_i[{slot, 5'd0} +: DATA_W];
  assign cnt_load   = (state == ST_IDLE);
  assign cnt_en     = (state == ST_BUSY);
  assign dbg_state  = state;

  wb_ic_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      slot          <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      bus.s_cyc_o   <= 1'b0;
      bus.s_stb_o   <= '0;
      bus.s_adr_o   <= '0;
      bus.s_dat_o   <= '0;
      bus.s_sel_o   <= '0;
      bus.s_we_o    <= 1'b0;
      err_o         <= 1'b0;
      err_slot_o    <= '0;
    end else begin
      bus.wbs_ack_o <= 1'b0;
      // A set later in this block overrides the clear in the same cycle.
      if (err_clr_i) begin
        err_o <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            bus.s_adr_o <= bus.wbs_adr_i;
            bus.s_dat_o <= bus.wbs_dat_i;
            bus.s_sel_o <= bus.wbs_sel_i;
            bus.s_we_o  <= bus.wbs_we_i;
            slot        <= req_slot;
            if (SLOT_MASK[req_slot]) begin
              state       <= ST_BUSY;
              bus.s_cyc_o <= 1'b1;
              bus.s_stb_o <= slot_onehot(req_slot);
            end else begin
              state         <= ST_DONE;
              bus.wbs_dat_o <= DEFAULT_DATA;
              err_o         <= 1'b1;
              err_slot_o    <= req_slot;
            end
          end
        end
        ST_BUSY: begin
          if (!bus.wbs_cyc_i) begin
            state       <= ST_IDLE;
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= '0;
          end else if (bus.s_ack_i[slot]) begin
            state         <= ST_DONE;
            bus.s_cyc_o   <= 1'b0;
            bus.s_stb_o   <= '0;
            bus.wbs_dat_o <= bus.s_we_o ? '0 : slot_rdata;
          end else if (cnt_tc) begin
            state         <= ST_DONE;
            bus.s_cyc_o   <= 1'b0;
            bus.s_stb_o   <= '0;
            bus.wbs_dat_o <= DEFAULT_DATA;
            err_o         <= 1'b1;
            err_slot_o    <= slot;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          bus.wbs_ack_o <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
